// File: rtl/mult_sequencer.sv
// Radix-2 shift-add MULT/MULTU engine owning HI/LO; product lands WIDTH+1 edges after start (less with MULT_EARLY_TERM_EN).
// No backpressure: a start while busy is dropped; stall_out holds the dependent op in ID until HI/LO are written.
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mf_req,
    input  logic             abort,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic                 neg_q;
    logic [CW-1:0]        count_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 accept;
    logic                 last_iter;
    logic                 early_done;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   iter_acc;
    logic [2*WIDTH-1:0]   product;

    assign accept    = start_mult & ~abort;
    assign last_iter = (count_q == CW'(WIDTH - 1));

    // Magnitudes are taken as unsigned, so the most negative operand maps to 2^(WIDTH-1).
    assign mag_a = (mult_sign & op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    assign mag_b = (mult_sign & op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;

    assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
    assign iter_acc = {sum, acc_q[WIDTH-1:1]};
    assign product  = neg_q ? (~acc_q + 1'b1) : acc_q;

`ifdef MULT_EARLY_TERM_EN
    logic [CW:0] shamt;
    assign early_done = (mplier_q == {WIDTH{1'b0}});
    assign shamt      = (CW+1)'(WIDTH) - {1'b0, count_q};
`else
    assign early_done = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (early_done || last_iter) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done    = ~abort;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mcand_q  <= mag_a;
                        mplier_q <= mag_b;
                        neg_q    <= mult_sign & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        acc_q    <= '0;
                        count_q  <= '0;
                    end
                end
                BUSY: begin
                    if (!abort) begin
`ifdef MULT_EARLY_TERM_EN
                        // Remaining multiplier bits are all zero: apply the outstanding shifts at once.
                        if (early_done) begin
                            acc_q <= acc_q >> shamt;
                        end else begin
                            acc_q    <= iter_acc;
                            mplier_q <= mplier_q >> 1;
                            count_q  <= count_q + 1'b1;
                        end
`else
                        acc_q    <= iter_acc;
                        mplier_q <= mplier_q >> 1;
                        count_q  <= count_q + 1'b1;
`endif
                    end
                end
                FIX: begin
                    if (!abort) begin
                        hi_q <= product[2*WIDTH-1:WIDTH];
                        lo_q <= product[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = (state_q != IDLE);
    assign stall_out = busy & mf_req;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: expected HI/LO and latency queued at start, checked when done fires.
module tb_mult_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start_mult = 1'b0;
    logic         mult_sign = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         mf_req = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall_out;

    mult_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_mult (start_mult),
        .mult_sign  (mult_sign),
        .op_a       (op_a),
        .op_b       (op_b),
        .mf_req     (mf_req),
        .abort      (abort),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .stall_out  (stall_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] prod;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   start_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        if (s) begin
            sa  = $signed({{32{a[31]}}, a});
            sbv = $signed({{32{b[31]}}, b});
            return sa * sbv;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic int exp_lat(input bit s, input logic [W-1:0] b);
`ifdef MULT_EARLY_TERM_EN
        logic [W-1:0] m;
        int h;
        m = (s && b[W-1]) ? (~b + 1'b1) : b;
        if (m == '0) return 2;
        h = 0;
        for (int i = 0; i < W; i++) if (m[i]) h = i;
        return (h + 3 > W + 1) ? W + 1 : h + 3;
`else
        return (s && b == '0) ? W + 1 : W + 1;
`endif
    endfunction

    task automatic start_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        @(negedge clk);
        mult_sign  = s;
        op_a       = a;
        op_b       = b;
        start_mult = 1'b1;
        e.prod = model(s, a, b);
        e.lat  = exp_lat(s, b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        start_cyc  = cyc;
        start_mult = 1'b0;
    endtask

    task automatic wait_done(input bit chk_stall);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
        if (!seen) begin
            if (sb.size() > 0) sb.delete(0);
            return;
        end
        if (chk_stall) chk("stall_in_fix", stall_out, 1);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("hi", hi, e.prod[63:32]);
        chk("lo", lo, e.prod[31:0]);
        chk("latency", cyc - start_cyc, e.lat);
        chk("busy_after", busy, 0);
        if (chk_stall) begin
            @(negedge clk);
            chk("stall_after", stall_out, 0);
        end
    endtask

    initial begin
        int  d0;
        bit  seen;
        bit  s;
        logic [W-1:0] a;
        logic [W-1:0] b;

        #1 rst_n = 1'b0;
        mf_req = 1'b1;
        #2;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall_out, 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mf_req = 1'b0;

        start_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0);

        // Back-to-back start, plus a stray start while busy that must not relatch.
        start_op(1, -32'sd3, 32'sd5);
        @(negedge clk);
        start_mult = 1'b1; mult_sign = 1'b0; op_a = 32'd9; op_b = 32'd9;
        @(negedge clk);
        start_mult = 1'b0;
        wait_done(0);

        start_op(1, 32'h8000_0000, 32'h8000_0000);
        wait_done(0);

        start_op(1, 32'd12345, -32'sd7);
        mf_req = 1'b1;
        @(negedge clk);
        chk("stall_busy", stall_out, 1);
        wait_done(1);
        mf_req = 1'b0;

        start_op(0, 32'd7, 32'd6);
        wait_done(0);
        start_op(0, 32'd123, 32'h0001_C800);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("lo_during_busy", lo, 42);
        abort = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 42);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        sb.delete(0);

        start_op(1, -32'sd100, 32'd77);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("fix_reached", seen, 1);
        abort = 1'b1;
        #1;
        chk("fix_abort_done", done, 0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("fix_abort_busy", busy, 0);
        chk("fix_abort_hi", hi, 0);
        chk("fix_abort_lo", lo, 42);
        sb.delete(0);

        @(negedge clk);
        start_mult = 1'b1; abort = 1'b1; mult_sign = 1'b0; op_a = 32'd2; op_b = 32'd2;
        @(posedge clk);
        #1;
        start_mult = 1'b0; abort = 1'b0;
        chk("idle_abort_start", busy, 0);

        start_op(0, 32'd1000, 32'hFFFF_0001);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_busy", busy, 0);
        sb.delete(0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(0, 32'd11, 32'd13);
        wait_done(0);

        start_op(0, 32'd3, 32'd5);
        wait_done(0);
        start_op(1, -32'sd5, 32'd0);
        wait_done(0);

        for (int i = 0; i < 6; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i % 2 == 1) ? $urandom : W'($urandom_range(0, 255));
            start_op(s, a, b);
            wait_done(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
